// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer: issues word-aligned fetches on the imem
// req/gnt/rvalid port, queues returned instructions with their PC and hands
// them to decode over valid/ready. A redirect flushes the queue and silently
// drops every response still in flight.
// Optional build macro: PREFETCH_ERR_EN adds imem_err_i / err_o and stops
// fetching after an errored response until the next redirect.
module instr_prefetch_buf #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        arst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
`ifdef PREFETCH_ERR_EN
  input  logic        imem_err_i,
  output logic        err_o,
`endif
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} state_t;
  state_t state;

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_cnt, outstanding, discard;
  logic [CW-1:0] fifo_cnt_n, out_n, disc_n;
  logic [CW:0]   sum_n;
  logic [31:0]   rsp_pc, redirect_addr, flush_target, push_instr;
  logic          stale;   // held request was issued before a redirect
  logic          fire, fire_new, fire_stale, rsp_keep, rsp_drop, push, pop;
  logic          credit_n, err_n;

`ifdef PREFETCH_ERR_EN
  logic          mem_err [DEPTH];
  logic          err_block;
`endif

  assign flush_target = flush_addr_i & ~32'h3;
  assign fire         = imem_req_o & imem_gnt_i;
  assign fire_new     = fire & ~stale;
  assign fire_stale   = fire & stale;
  assign rsp_keep     = imem_rvalid_i & (discard == '0);
  assign rsp_drop     = imem_rvalid_i & (discard != '0);
  assign push         = rsp_keep & ~flush_i;
  assign pop          = valid_o & ready_i;

  assign valid_o = (fifo_cnt != '0);
  assign instr_o = mem_instr[rd_ptr];
  assign pc_o    = mem_pc[rd_ptr];
`ifdef PREFETCH_ERR_EN
  assign err_o   = valid_o & mem_err[rd_ptr];
`endif

  // Next-cycle occupancy, in-flight and discard counts; credit for the next request
  always_comb begin
    fifo_cnt_n = fifo_cnt;
    out_n      = outstanding;
    disc_n     = discard;
    if (flush_i) begin
      fifo_cnt_n = '0;
      out_n      = '0;
      disc_n     = discard + outstanding + CW'(fire) - CW'(imem_rvalid_i);
    end else begin
      if (push && !pop)      fifo_cnt_n = fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt_n = fifo_cnt - 1'b1;
      out_n  = outstanding + CW'(fire_new) - CW'(rsp_keep);
      disc_n = discard + CW'(fire_stale) - CW'(rsp_drop);
    end
    sum_n    = {1'b0, fifo_cnt_n} + {1'b0, out_n} + {1'b0, disc_n};
    credit_n = (sum_n < (CW+1)'(DEPTH));
  end

  // Error latch next value and the instruction word actually stored
  always_comb begin
    err_n      = 1'b0;
    push_instr = imem_rdata_i;
`ifdef PREFETCH_ERR_EN
    err_n = flush_i ? 1'b0 : (err_block | (push & imem_err_i));
    if (imem_err_i) push_instr = 32'h0000_0013;
`endif
  end

  // Response FIFO storage and pointers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
`ifdef PREFETCH_ERR_EN
        mem_err[i]   <= 1'b0;
`endif
      end
    end else if (flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= push_instr;
        mem_pc[wr_ptr]    <= rsp_pc;
`ifdef PREFETCH_ERR_EN
        mem_err[wr_ptr]   <= imem_err_i;
`endif
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt_n;
    end
  end

  // Fetch FSM: request/address generation, transaction bookkeeping
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state         <= S_BOOT;
      imem_req_o    <= 1'b0;
      imem_addr_o   <= BOOT_ADDR;
      redirect_addr <= BOOT_ADDR;
      rsp_pc        <= BOOT_ADDR;
      stale         <= 1'b0;
      outstanding   <= '0;
      discard       <= '0;
`ifdef PREFETCH_ERR_EN
      err_block     <= 1'b0;
`endif
    end else begin
      outstanding <= out_n;
      discard     <= disc_n;
`ifdef PREFETCH_ERR_EN
      err_block   <= err_n;
`endif
      if (flush_i)   rsp_pc <= flush_target;
      else if (push) rsp_pc <= rsp_pc + 32'd4;

      if (state != S_BOOT && imem_req_o && !imem_gnt_i) begin
        // Request may not be retracted: keep it and its address until granted.
        state <= S_HOLD;
        if (flush_i) begin
          stale         <= 1'b1;
          redirect_addr <= flush_target;
        end
      end else begin
        state      <= S_RUN;
        imem_req_o <= credit_n & ~err_n;
        stale      <= 1'b0;
        if (flush_i)    imem_addr_o <= flush_target;
        else if (fire)  imem_addr_o <= stale ? redirect_addr : imem_addr_o + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Self-checking bench for instr_prefetch_buf: a clock-stepped memory model
// answers granted requests in order, and a scoreboard of expected PCs is
// filled on every live grant and emptied on every accepted instruction.
module tb_instr_prefetch_buf;
  logic        clk = 1'b0;
  logic        arst_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i, flush_addr_i, instr_o, pc_o;
  logic        flush_i, valid_o, ready_i;
`ifdef PREFETCH_ERR_EN
  logic        imem_err_i, err_o;
  int          err_idx = -1;
`endif

  always #5 clk = ~clk;

  instr_prefetch_buf #(.DEPTH(4), .BOOT_ADDR(32'h0000_0000)) dut (
    .clk_i(clk), .arst_i(arst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
`ifdef PREFETCH_ERR_EN
    .imem_err_i(imem_err_i), .err_o(err_o),
`endif
    .flush_i(flush_i), .flush_addr_i(flush_addr_i),
    .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } pop_t;

  mreq_t       memq[$];
  logic [31:0] expq[$];
  pop_t        pop_log[$];
  int          errors = 0, checks = 0, cyc = 0;
  int          gnt_mode = 0, rdy_mode = 0, lat_min = 1, lat_max = 1;
  int          grants = 0, rsp_cnt = 0;
  bit          hold_stale = 0, sb_en = 1, flush_req = 0;
  logic [31:0] flush_tgt = '0, next_addr = '0;
  logic        s_req, s_valid;
  logic [31:0] s_addr;

  // One clock: drive inputs at negedge, sample outputs 1ns later, update models
  task automatic step();
    logic fire, stale_fire, do_rv, e_err;
    logic [31:0] e;
    @(negedge clk);
    imem_gnt_i = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 1) == 1);
    ready_i    = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 2) != 0);
    do_rv      = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rvalid_i = do_rv;
    imem_rdata_i  = do_rv ? ~memq[0].addr : 32'h0;
`ifdef PREFETCH_ERR_EN
    imem_err_i = do_rv && (rsp_cnt == err_idx);
`endif
    flush_i      = flush_req;
    flush_addr_i = flush_tgt;
    #1;
    s_req = imem_req_o; s_valid = valid_o; s_addr = imem_addr_o;
    fire = imem_req_o && imem_gnt_i;
    if (fire) begin
      memq.push_back('{imem_addr_o, cyc + $urandom_range(lat_min, lat_max)});
      grants++;
      stale_fire = hold_stale || flush_i;
      hold_stale = 0;
      if (!stale_fire) begin
        checks++;
        if (imem_addr_o !== next_addr) begin
          errors++;
          $display("FAIL req_addr: got %h want %h (cyc %0d)", imem_addr_o, next_addr, cyc);
        end
        expq.push_back(next_addr);
        next_addr = next_addr + 32'd4;
      end
    end
    if (do_rv) begin
      void'(memq.pop_front());
      rsp_cnt++;
    end
    if (valid_o && ready_i && !flush_i) begin
      e_err = 1'b0;
`ifdef PREFETCH_ERR_EN
      e_err = err_o;
`endif
      pop_log.push_back('{pc_o, instr_o, e_err});
      if (sb_en) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_instr: got pc %h instr %h, want nothing", pc_o, instr_o);
        end else begin
          e = expq.pop_front();
          if (pc_o !== e || instr_o !== ~e) begin
            errors++;
            $display("FAIL sb_data: got pc %h instr %h want pc %h instr %h", pc_o, instr_o, e, ~e);
          end
        end
      end
    end
    if (flush_i) begin
      expq.delete();
      next_addr = flush_tgt & ~32'h3;
      if (imem_req_o && !imem_gnt_i) hold_stale = 1;
      flush_req = 0;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_flush(input logic [31:0] t);
    flush_req = 1; flush_tgt = t;
    step();
  endtask

  task automatic check_pc(input string name, input int idx, input logic [31:0] want);
    checks++;
    if (pop_log.size() <= idx) begin
      errors++;
      $display("FAIL %s: only %0d instrs delivered, want pc %h at index %0d", name, pop_log.size(), want, idx);
    end else if (pop_log[idx].pc !== want) begin
      errors++;
      $display("FAIL %s: got pc %h want %h", name, pop_log[idx].pc, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_i = 1; flush_i = 0; flush_req = 0; imem_gnt_i = 0; imem_rvalid_i = 0; ready_i = 0;
    imem_rdata_i = '0; flush_addr_i = '0;
`ifdef PREFETCH_ERR_EN
    imem_err_i = 0;
`endif
    memq.delete(); expq.delete(); pop_log.delete();
    hold_stale = 0; next_addr = 32'h0; grants = 0; rsp_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    arst_i = 0;
  endtask

  task automatic test_reset();
    int first_valid;
    @(negedge clk);
    arst_i = 1; flush_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; ready_i = 0;
    imem_rdata_i = '0; flush_addr_i = '0;
`ifdef PREFETCH_ERR_EN
    imem_err_i = 0;
`endif
    #3;
    checks += 5;
    if (imem_req_o !== 1'b0)   begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
    if (valid_o !== 1'b0)      begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    if (instr_o !== 32'h0)     begin errors++; $display("FAIL rst_instr: got %h want 0", instr_o); end
    if (pc_o !== 32'h0)        begin errors++; $display("FAIL rst_pc: got %h want 0", pc_o); end
`ifdef PREFETCH_ERR_EN
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
`endif
    @(negedge clk);
    arst_i = 0;
    gnt_mode = 1; rdy_mode = 1; lat_min = 1; lat_max = 1;
    first_valid = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
          errors++; $display("FAIL boot_req: got req %b addr %h want req 1 addr 0", s_req, s_addr);
        end
      end
      if (s_valid === 1'b1 && first_valid == 0) first_valid = k;
    end
    checks++;
    if (first_valid != 3) begin errors++; $display("FAIL boot_latency: got %0d want 3", first_valid); end
    check_pc("boot_first_pc", 0, 32'h0);
  endtask

  task automatic test_stall();
    do_reset();
    gnt_mode = 1; rdy_mode = 0; lat_min = 1; lat_max = 1;
    steps(15);
    checks += 3;
    if (grants != 4)    begin errors++; $display("FAIL stall_grants: got %0d want 4", grants); end
    if (s_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", s_req); end
    if (s_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", s_valid); end
    rdy_mode = 1;
    steps(20);
    for (int i = 0; i < 4; i++) check_pc("stall_drain_pc", i, 32'(4 * i));
    checks++;
    if (grants <= 4) begin errors++; $display("FAIL stall_resume: got %0d grants want >4", grants); end
  endtask

  task automatic test_flush();
    do_reset();
    gnt_mode = 1; rdy_mode = 1; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && memq.size() < 3; i++) step();
    checks++;
    if (memq.size() != 3) begin errors++; $display("FAIL flush_setup: got %0d outstanding want 3", memq.size()); end
    pop_log.delete();
    do_flush(32'h0000_1002);
    steps(25);
    check_pc("flush_first_pc", 0, 32'h0000_1000);
  endtask

  task automatic test_hold_flush();
    do_reset();
    gnt_mode = 0; rdy_mode = 1; lat_min = 1; lat_max = 1;
    steps(3);
    pop_log.delete();
    do_flush(32'h0000_2000);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h0) begin
        errors++; $display("FAIL hold_keep: got req %b addr %h want req 1 addr 0", s_req, s_addr);
      end
    end
    gnt_mode = 1;
    step();
    checks++;
    if (s_addr !== 32'h0) begin errors++; $display("FAIL hold_grant_addr: got %h want 0", s_addr); end
    step();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h2000) begin
      errors++; $display("FAIL hold_target_req: got req %b addr %h want req 1 addr 2000", s_req, s_addr);
    end
    steps(15);
    check_pc("hold_first_pc", 0, 32'h0000_2000);
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_mode = 1; rdy_mode = 1; lat_min = 1; lat_max = 1;
    steps(3);
    pop_log.delete();
    do_flush(32'hFFFF_FFF8);
    steps(15);
    check_pc("wrap_pc0", 0, 32'hFFFF_FFF8);
    check_pc("wrap_pc1", 1, 32'hFFFF_FFFC);
    check_pc("wrap_pc2", 2, 32'h0000_0000);
  endtask

  task automatic test_back_to_back();
    do_reset();
    gnt_mode = 1; rdy_mode = 1; lat_min = 2; lat_max = 3;
    steps(4);
    pop_log.delete();
    do_flush(32'h0000_0400);
    do_flush(32'h0000_0800);
    steps(20);
    check_pc("b2b_first_pc", 0, 32'h0000_0800);
    check_pc("b2b_second_pc", 1, 32'h0000_0804);
  endtask

  task automatic test_random();
    do_reset();
    gnt_mode = 2; rdy_mode = 2; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        flush_req = 1;
        flush_tgt = $urandom();
      end
      step();
    end
    gnt_mode = 0; rdy_mode = 1;
    steps(30);
    checks += 2;
    if (memq.size() != 0) begin errors++; $display("FAIL rand_mem_drain: got %0d pending want 0", memq.size()); end
    if (expq.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d undelivered want 0", expq.size()); end
  endtask

`ifdef PREFETCH_ERR_EN
  task automatic test_err();
    int req_hi;
    do_reset();
    sb_en = 0; err_idx = 1;
    gnt_mode = 1; rdy_mode = 1; lat_min = 1; lat_max = 1;
    steps(4);
    req_hi = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_req === 1'b1) req_hi++;
    end
    checks += 3;
    if (req_hi != 0) begin errors++; $display("FAIL err_req_stop: got %0d req cycles want 0", req_hi); end
    if (pop_log.size() < 2 || pop_log[0].err !== 1'b0 || pop_log[0].instr !== ~32'h0) begin
      errors++; $display("FAIL err_first: got %0d entries want clean pc 0 first", pop_log.size());
    end else if (pop_log[1].err !== 1'b1 || pop_log[1].instr !== 32'h13 || pop_log[1].pc !== 32'h4) begin
      errors++; $display("FAIL err_entry: got err %b instr %h pc %h want 1 00000013 4",
                         pop_log[1].err, pop_log[1].instr, pop_log[1].pc);
    end
    err_idx = -1;
    pop_log.delete();
    do_flush(32'h0000_3000);
    steps(10);
    check_pc("err_resume_pc", 0, 32'h0000_3000);
    if (pop_log.size() > 0 && pop_log[0].err !== 1'b0) begin
      errors++; $display("FAIL err_resume_flag: got %b want 0", pop_log[0].err);
    end
    sb_en = 1;
  endtask
`endif

  initial begin
    arst_i = 1; flush_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; ready_i = 0;
    imem_rdata_i = '0; flush_addr_i = '0;
`ifdef PREFETCH_ERR_EN
    imem_err_i = 0;
`endif
    test_reset();
    test_stall();
    test_flush();
    test_hold_flush();
    test_wrap();
    test_back_to_back();
    test_random();
`ifdef PREFETCH_ERR_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
